ifetch_responder: RTL and testbench
===================================

Name: ifetch_responder

Overview:
- Instruction-memory responder for the uPOWER fetch path.
- The fetch side issues 64-bit PC requests over a valid/ready handshake.
- This block reads a byte-addressed instruction store and returns the 32-bit instruction, tagged with its PC and an error code, through an in-order response FIFO with backpressure.
- A byte load port fills the store before execution.

Parameters:
- BASE_ADDR, 64'h0000_0000_0004_0000: byte address mapped to store offset 0.
- MEM_BYTES, 1024: store size in bytes; multiple of 4, ≥ 4.
- RESP_DEPTH, 4: response FIFO entries; power of two, ≥ 2.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: reset, synchronous, active-high.
- req_valid, input, 1: fetch request present.
- req_ready, output, 1: request can be accepted this cycle.
- req_pc, input, 64: fetch byte address.
- resp_valid, output, 1: FIFO head valid.
- resp_ready, input, 1: consumer takes head this cycle.
- resp_instr, output, 32: instruction at head.
- resp_pc, output, 64: PC of head request.
- resp_err, output, 2: bit0 = misaligned, bit1 = out of range.
- ld_en, input, 1: byte write strobe.
- ld_addr, input, $clog2(MEM_BYTES): store byte offset.
- ld_data, input, 8: byte to write.
- occupancy, output, $clog2(RESP_DEPTH)+1: FIFO count plus s1_valid.

Behaviour:
- Accept: a request is accepted when req_valid && req_ready are both high at a posedge.
- req_ready: equals !rst && (fifo_count + s1_valid) < RESP_DEPTH. A same-cycle pop is not credited, so the check is conservative.
- Stage S1: on accept, S1 captures req_pc, the 32-bit word read from the store, and the error bits; s1_valid is set to 1. Otherwise s1_valid is cleared to 0.
- FIFO push: when s1_valid is 1, S1 is pushed into the FIFO at the next posedge.
- Latency: a request accepted at edge k has its response at the FIFO head, with resp_valid = 1, after edge k+1.
- Throughput: one request per cycle is sustained while resp_ready stays high.
- Pop: occurs when resp_valid && resp_ready. Push and pop may happen in the same cycle; the count is then unchanged.
- Ordering: responses leave strictly in request order.
- Outputs while empty: when the FIFO is empty, resp_valid, resp_instr, resp_pc and resp_err are all 0.
- Address rules:
  - Offset = req_pc - BASE_ADDR, computed in 64-bit unsigned arithmetic.
  - Misaligned when req_pc[1:0] != 0.
  - Out of range when req_pc < BASE_ADDR or offset > MEM_BYTES-4.
  - Both error bits may be set together.
  - Any error forces instr = 32'h0; no store read is used.
- Word assembly: the word is built from bytes offset..offset+3, with offset+0 in instr[7:0] (little-endian).
- Load port:
  - Writes mem[ld_addr] = ld_data at the posedge when ld_en = 1.
  - A fetch accepted in the same cycle that touches the same byte sees the old value (read-before-write).
  - Loads are independent of the handshake and allowed at any time.
- Reset:
  - FIFO pointers and count go to 0, s1_valid goes to 0, and all resp_* outputs are 0.
  - req_ready is 0 while rst = 1.
  - Asserting rst mid-operation discards in-flight S1 and all FIFO contents; no stale response appears afterwards.
  - The store contents are not cleared by reset.
- Overflow and underflow: a push into a full FIFO cannot occur by construction of req_ready; a pop while empty is ignored.

Optional Feature:
- Macro: IFETCH_BIG_ENDIAN_EN.
- Defined: words are assembled big-endian, with offset+0 in instr[31:24], matching uPOWER big-endian mode.
- Undefined: little-endian assembly as in Behaviour.
- The handshake, latency and error rules are identical in both builds.

Test Plan:
- Load 8'h11, 8'h22, 8'h33, 8'h44 at offsets 0–3, then request PC 64'h40000 with resp_ready = 1. Response: resp_valid two edges after the request, resp_instr = 32'h44332211 (32'h11223344 with IFETCH_BIG_ENDIAN_EN), resp_pc = 64'h40000, resp_err = 2'b00.
- Request PC 64'h40002, then PC 64'h3FFFC, then PC 64'h40400. Responses in order: err = 01, instr = 0; err = 10, instr = 0; err = 10, instr = 0.
- Hold resp_ready = 0 and drive req_valid for 6 cycles with PCs 40000, 40004, … Exactly 4 requests are accepted, req_ready goes low and occupancy = 4. Then raise resp_ready: the 4 responses drain one per cycle in PC order, and req_ready returns high.
- Hold resp_ready = 1 and issue 8 back-to-back requests. All are accepted on consecutive cycles, responses appear on 8 consecutive cycles starting 2 edges after the first, and occupancy never exceeds 2.
- Accept 3 requests with resp_ready = 0, then pulse rst for 1 cycle. resp_valid = 0 and occupancy = 0 after reset; a new request to PC 64'h40000 returns the previously loaded data, showing memory is retained.
- In the same cycle, load ld_addr = 0 with 8'hAA and accept a request to PC 64'h40000. The response shows the old byte; a repeat request shows 8'hAA.

Source files
------------

// File: rtl/ifetch_responder.sv
// rtl/ifetch_responder.sv - instruction-store fetch responder with an S1 read stage and an in-order response FIFO
// Optional build macro IFETCH_BIG_ENDIAN_EN selects big-endian word assembly.
module ifetch_responder #(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0004_0000,
    parameter int          MEM_BYTES  = 1024,
    parameter int          RESP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [63:0]                    req_pc,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_instr,
    output logic [63:0]                    resp_pc,
    output logic [1:0]                     resp_err,
    input  logic                           ld_en,
    input  logic [$clog2(MEM_BYTES)-1:0]   ld_addr,
    input  logic [7:0]                     ld_data,
    output logic [$clog2(RESP_DEPTH):0]    occupancy
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;

    // Store is deliberately not reset; reads are combinational so a same-edge load is not visible.
    logic [7:0] mem_q [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    logic [63:0] offset;
    logic [AW-1:0] idx;
    logic misaligned, out_of_range;
    logic [31:0] word;

    always_comb begin
        offset       = req_pc - BASE_ADDR;
        idx          = offset[AW-1:0];
        misaligned   = (req_pc[1:0] != 2'b00);
        out_of_range = (req_pc < BASE_ADDR) || (offset > 64'(MEM_BYTES - 4));
`ifdef IFETCH_BIG_ENDIAN_EN
        word = {mem_q[idx], mem_q[idx + AW'(1)], mem_q[idx + AW'(2)], mem_q[idx + AW'(3)]};
`else
        word = {mem_q[idx + AW'(3)], mem_q[idx + AW'(2)], mem_q[idx + AW'(1)], mem_q[idx]};
`endif
        if (misaligned || out_of_range) begin
            word = 32'h0;
        end
    end

    logic        accept, push, pop;
    logic        s1_valid_q, s1_valid_d;
    logic [63:0] s1_pc_q, s1_pc_d;
    logic [31:0] s1_instr_q, s1_instr_d;
    logic [1:0]  s1_err_q, s1_err_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [63:0] fifo_pc_q    [RESP_DEPTH];
    logic [31:0] fifo_instr_q [RESP_DEPTH];
    logic [1:0]  fifo_err_q   [RESP_DEPTH];

    // Ready counts the S1 entry as occupied and ignores a same-cycle pop, so a push never overflows.
    assign occupancy  = count_q + CW'(s1_valid_q);
    assign req_ready  = !rst && (occupancy < CW'(RESP_DEPTH));
    assign accept     = req_valid && req_ready;
    assign push       = s1_valid_q;
    assign resp_valid = (count_q != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_instr = resp_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign resp_pc    = resp_valid ? fifo_pc_q[rd_ptr_q]    : 64'h0;
    assign resp_err   = resp_valid ? fifo_err_q[rd_ptr_q]   : 2'b00;

    always_comb begin
        s1_valid_d = accept;
        s1_pc_d    = accept ? req_pc : s1_pc_q;
        s1_instr_d = accept ? word : s1_instr_q;
        s1_err_d   = accept ? {out_of_range, misaligned} : s1_err_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_pc_q    <= 64'h0;
            s1_instr_q <= 32'h0;
            s1_err_q   <= 2'b00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pc_q    <= s1_pc_d;
            s1_instr_q <= s1_instr_d;
            s1_err_q   <= s1_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset: resp_* are gated by count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc_q[wr_ptr_q]    <= s1_pc_q;
            fifo_instr_q[wr_ptr_q] <= s1_instr_q;
            fifo_err_q[wr_ptr_q]   <= s1_err_q;
        end
    end
endmodule

// File: tb/tb_ifetch_responder.sv
// tb/tb_ifetch_responder.sv - directed self-checking bench for ifetch_responder
module tb_ifetch_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [63:0] resp_pc;
    logic [1:0]  resp_err;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [7:0]  ld_data;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

`ifdef IFETCH_BIG_ENDIAN_EN
    localparam logic [31:0] W0      = 32'h11223344;
    localparam logic [31:0] W0_AA   = 32'hAA223344;
    localparam logic [31:0] W_TOP   = 32'hDEADBEEF;
`else
    localparam logic [31:0] W0      = 32'h44332211;
    localparam logic [31:0] W0_AA   = 32'h443322AA;
    localparam logic [31:0] W_TOP   = 32'hEFBEADDE;
`endif

    ifetch_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_pc    (resp_pc),
        .resp_err   (resp_err),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [9:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        step();
        checks++;
        if (resp_valid !== 1'b0 || occupancy !== 3'd0 || resp_pc !== 64'h0 || resp_instr !== 32'h0 || resp_err !== 2'b00) begin
            errors++; $display("FAIL reset_outputs: valid=%b occ=%0d pc=%h instr=%h err=%b want all 0", resp_valid, occupancy, resp_pc, resp_instr, resp_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_basic();
        load_byte(10'd0, 8'h11);
        load_byte(10'd1, 8'h22);
        load_byte(10'd2, 8'h33);
        load_byte(10'd3, 8'h44);
        resp_ready = 1'b1;
        req_valid = 1'b1; req_pc = 64'h40000;
        step();
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || occupancy !== 3'd1) begin
            errors++; $display("FAIL basic_s1: valid=%b occ=%0d want 0/1", resp_valid, occupancy);
        end
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_instr !== W0 || resp_pc !== 64'h40000 || resp_err !== 2'b00) begin
            errors++; $display("FAIL basic_resp: valid=%b instr=%h pc=%h err=%b want 1/%h/40000/00", resp_valid, resp_instr, resp_pc, resp_err, W0);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0 || resp_instr !== 32'h0 || resp_pc !== 64'h0) begin
            errors++; $display("FAIL basic_empty: valid=%b instr=%h pc=%h want 0", resp_valid, resp_instr, resp_pc);
        end
    endtask

    task automatic test_errors();
        logic [63:0] pcs  [5] = '{64'h40002, 64'h3FFFC, 64'h40400, 64'h3FFFE, 64'h403FC};
        logic [1:0]  errs [5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [31:0] ins  [5];
        ins = '{32'h0, 32'h0, 32'h0, 32'h0, W_TOP};
        load_byte(10'd1020, 8'hDE);
        load_byte(10'd1021, 8'hAD);
        load_byte(10'd1022, 8'hBE);
        load_byte(10'd1023, 8'hEF);
        resp_ready = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c < 5) begin req_valid = 1'b1; req_pc = pcs[c]; end
            else req_valid = 1'b0;
            step();
            if (c >= 1) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_pc !== pcs[c-1] || resp_err !== errs[c-1] || resp_instr !== ins[c-1]) begin
                    errors++; $display("FAIL err_resp%0d: valid=%b pc=%h err=%b instr=%h want 1/%h/%b/%h", c-1, resp_valid, resp_pc, resp_err, resp_instr, pcs[c-1], errs[c-1], ins[c-1]);
                end
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_pc = 64'h40000 + 64'(4 * acc);
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        checks++;
        if (acc != 4 || req_ready !== 1'b0 || occupancy !== 3'd4) begin
            errors++; $display("FAIL bp_fill: accepted=%0d ready=%b occ=%0d want 4/0/4", acc, req_ready, occupancy);
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_pc !== 64'h40000 + 64'(4 * i) || resp_err !== 2'b00) begin
                errors++; $display("FAIL bp_drain%0d: valid=%b pc=%h err=%b want 1/%h/00", i, resp_valid, resp_pc, resp_err, 64'h40000 + 64'(4 * i));
            end
            step();
        end
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || occupancy !== 3'd0) begin
            errors++; $display("FAIL bp_done: valid=%b ready=%b occ=%0d want 0/1/0", resp_valid, req_ready, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                req_valid = 1'b1; req_pc = 64'h40000 + 64'(4 * c);
                checks++;
                if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", c, req_ready); end
            end else req_valid = 1'b0;
            step();
            checks++;
            if (occupancy > 3'd2) begin errors++; $display("FAIL b2b_occ%0d: got %0d want <=2", c, occupancy); end
            if (c >= 1) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_pc !== 64'h40000 + 64'(4 * (c - 1))) begin
                    errors++; $display("FAIL b2b_resp%0d: valid=%b pc=%h want 1/%h", c-1, resp_valid, resp_pc, 64'h40000 + 64'(4 * (c - 1)));
                end
            end
        end
        step();
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: valid=%b want 0", resp_valid); end
    endtask

    task automatic test_reset_midop();
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_pc = 64'h40004 + 64'(4 * i);
            step();
        end
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", req_ready); end
        step();
        rst = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++; $display("FAIL midrst_clear: valid=%b occ=%0d want 0/0", resp_valid, occupancy);
        end
        step();
        step();
        checks++;
        if (resp_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++; $display("FAIL midrst_stale: valid=%b occ=%0d want 0/0", resp_valid, occupancy);
        end
        resp_ready = 1'b1;
        req_valid = 1'b1; req_pc = 64'h40000;
        step();
        req_valid = 1'b0;
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_instr !== W0 || resp_pc !== 64'h40000) begin
            errors++; $display("FAIL midrst_retain: valid=%b instr=%h pc=%h want 1/%h/40000", resp_valid, resp_instr, resp_pc, W0);
        end
        step();
    endtask

    task automatic test_load_rbw();
        resp_ready = 1'b1;
        ld_en = 1'b1; ld_addr = 10'd0; ld_data = 8'hAA;
        req_valid = 1'b1; req_pc = 64'h40000;
        step();
        ld_en = 1'b0; req_valid = 1'b0;
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_instr !== W0) begin
            errors++; $display("FAIL rbw_old: valid=%b instr=%h want 1/%h", resp_valid, resp_instr, W0);
        end
        step();
        req_valid = 1'b1; req_pc = 64'h40000;
        step();
        req_valid = 1'b0;
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_instr !== W0_AA) begin
            errors++; $display("FAIL rbw_new: valid=%b instr=%h want 1/%h", resp_valid, resp_instr, W0_AA);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_pc = 64'h0; resp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = 8'h0;
        test_reset();
        test_basic();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_load_rbw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
